tcdm_sram_responder: RTL and testbench
======================================

TCDM_SRAM_RESPONDER -- requirements
Module: tcdm_sram_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: number of 32-bit words of backing storage.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1C00_0000: byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 2, legal range 1..8: cycles from handshake to response.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, legal range 1..8: accepted requests not yet responded.
REQ-005 SHALL have parameter STALL_EVERY, default 0: grant-throttle period; 0 disables throttling.
REQ-006 clk_i  in  1  clock; all state updates on the rising edge.
REQ-007 rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 req_i  in  1  request valid from initiator.
REQ-009 add_i  in  32  byte address.
REQ-010 wen_i  in  1  write enable, active-low (0 = write, 1 = read).
REQ-011 wdata_i  in  32  write data.
REQ-012 be_i  in  4  byte enables; bit n enables wdata_i[8n+7:8n].
REQ-013 gnt_o  out  1  grant, combinational.
REQ-014 r_valid_o  out  1  response valid, registered.
REQ-015 r_rdata_o  out  32  response data, registered.
REQ-016 r_opc_o  out  1  response error flag, registered.

Function
REQ-017 gnt_o SHALL equal req_i AND (outstanding < MAX_OUTSTANDING, or a response retires this cycle) AND NOT stall.
REQ-018 Handshake SHALL occur in any cycle with req_i=1 and gnt_o=1; at most one per cycle.
REQ-019 Request SHALL be in range when BASE_ADDR <= add_i < BASE_ADDR+4*MEM_WORDS and add_i[1:0]=0; index = (add_i-BASE_ADDR)>>2.
REQ-020 In-range write handshake SHALL update only the enabled bytes of the indexed word at the end of the handshake cycle; be_i=0 SHALL write nothing and still respond.
REQ-021 In-range read handshake SHALL sample the indexed word at the end of the handshake cycle, including any write completed by the previous handshake (read-after-write coherent).
REQ-022 Out-of-range or misaligned handshake SHALL leave memory unchanged and produce r_opc_o=1, r_rdata_o=32'hBADA_CCE5.
REQ-023 A handshake in cycle t SHALL produce r_valid_o=1 for exactly one cycle, t+LATENCY; responses SHALL be strictly in order with no reordering, merging or dropping.
REQ-024 Read response r_rdata_o SHALL be the sampled word with r_opc_o=0; write response SHALL be r_rdata_o=0, r_opc_o=0.
REQ-025 When r_valid_o=0, r_rdata_o SHALL be 0 and r_opc_o SHALL be 0.
REQ-026 Outstanding counter SHALL increment on handshake, decrement on r_valid_o, and stay unchanged when both occur in one cycle; it SHALL never exceed MAX_OUTSTANDING or underflow.
REQ-027 Response pipeline SHALL be a LATENCY-deep shift register of {valid, rdata, opc}; no back-pressure exists on responses.
REQ-028 With STALL_EVERY=N>0, a free-running cycle counter SHALL wrap 0..N-1, and stall SHALL be 1 when the counter equals N-1; N=1 SHALL stall every cycle.
REQ-029 Input changes while req_i=1 and gnt_o=0 SHALL have no effect; only handshake-cycle values are used.

Reset
REQ-030 On rst_ni=0, regardless of clock: r_valid_o=0, r_rdata_o=0, r_opc_o=0, outstanding=0, stall counter=0, pipeline valid bits=0.
REQ-031 Responses in flight at reset assertion SHALL be discarded; none SHALL appear after reset release.
REQ-032 Memory contents SHALL NOT be affected by reset; reads of never-written words are undefined.
REQ-033 gnt_o SHALL be 0 while rst_ni=0.

Verification
REQ-034 Write 32'hDEAD_BEEF, be=4'hF, to 0x1C00_0010, then read it back -> read r_valid_o exactly 2 cycles after its handshake, r_rdata_o=32'hDEAD_BEEF, r_opc_o=0.
REQ-035 Word holds 32'h0000_0000; write 32'hAABB_CCDD with be=4'b0101, then read -> 32'h00BB_00DD.
REQ-036 Read 0x1C00_1000 (end of range) and read 0x1C00_0002 (misaligned) -> both r_opc_o=1, r_rdata_o=32'hBADA_CCE5, and memory is unchanged.
REQ-037 LATENCY=4, MAX_OUTSTANDING=2, req_i held high for 8 back-to-back reads -> gnt_o pattern 1,1,0,0,1,1,0,0; outstanding never exceeds 2; 8 in-order responses.
REQ-038 STALL_EVERY=3, req_i held high from reset release -> gnt_o=0 on cycles 2,5,8,...; all other cycles grant.
REQ-039 Assert rst_ni=0 with 2 responses in flight -> outputs go to 0 immediately and no r_valid_o occurs after release until a new handshake.

Source files
------------

// File: rtl/tcdm_sram_responder.sv
// tcdm_sram_responder: TCDM slave backed by a word-addressed SRAM model.
// Responses come back a fixed LATENCY cycles after the handshake. Grants are
// throttled by an outstanding-request limit and an optional periodic stall.
// Ports:
//   clk_i, rst_ni             clock; asynchronous active-low reset
//   req_i, add_i, wen_i,      request channel (wen_i=0 writes, wen_i=1 reads);
//   wdata_i, be_i             be_i[n] enables wdata_i[8n+7:8n]
//   gnt_o                     combinational grant
//   r_valid_o, r_rdata_o,     registered response; r_opc_o=1 flags an
//   r_opc_o                   out-of-range or misaligned access
module tcdm_sram_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h1C00_0000,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STALL_EVERY     = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [31:0] add_i,
    input  logic        wen_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        gnt_o,
    output logic        r_valid_o,
    output logic [31:0] r_rdata_o,
    output logic        r_opc_o
);
    localparam int unsigned IW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = STALL_EVERY > 1 ? $clog2(STALL_EVERY) : 1;
    localparam logic [31:0] SPAN = 32'(4 * MEM_WORDS);
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_EVERY > 0 ? STALL_EVERY - 1 : 0);
    localparam logic [31:0] ERR_DATA = 32'hBADA_CCE5;

    logic [31:0]        mem [MEM_WORDS];
    logic [31:0]        off;
    logic [IW-1:0]      idx;
    logic               in_range;
    logic               stall;
    logic [OW-1:0]      outstanding;
    logic [SW-1:0]      stall_cnt;
    logic [LATENCY-1:0] pv;
    logic [LATENCY-1:0] po;
    logic [31:0]        pd [LATENCY];

    // Subtraction wraps for addresses below BASE_ADDR, so the lower bound is
    // checked explicitly as well.
    assign off      = add_i - BASE_ADDR;
    assign in_range = add_i >= BASE_ADDR && off < SPAN && add_i[1:0] == 2'b00;
    assign idx      = off[IW+1:2];
    assign stall    = STALL_EVERY != 0 && stall_cnt == STALL_LAST;
    // A response retiring this cycle frees a slot, so a full counter still grants.
    assign gnt_o    = rst_ni && req_i && (outstanding < MAX_O || r_valid_o) && !stall;

    assign r_valid_o = pv[LATENCY-1];
    assign r_rdata_o = pd[LATENCY-1];
    assign r_opc_o   = po[LATENCY-1];

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk_i) begin
        if (gnt_o && in_range && !wen_i)
            for (int n = 0; n < 4; n++)
                if (be_i[n]) mem[idx][8*n +: 8] <= wdata_i[8*n +: 8];
    end

    // Empty pipeline slots carry zero data so idle outputs stay at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding <= '0;
            stall_cnt   <= '0;
            pv          <= '0;
            po          <= '0;
            for (int k = 0; k < LATENCY; k++) pd[k] <= '0;
        end else begin
            outstanding <= outstanding + OW'(gnt_o) - OW'(r_valid_o);
            stall_cnt   <= stall_cnt == STALL_LAST ? '0 : stall_cnt + 1'b1;
            pv[0]       <= gnt_o;
            po[0]       <= gnt_o && !in_range;
            pd[0]       <= !gnt_o ? '0 : !in_range ? ERR_DATA : wen_i ? mem[idx] : '0;
            for (int k = 1; k < LATENCY; k++) begin
                pv[k] <= pv[k-1];
                po[k] <= po[k-1];
                pd[k] <= pd[k-1];
            end
        end
    end
endmodule

// File: tb/tb_tcdm_sram_responder.sv
// tb_tcdm_sram_responder: directed vectors and corner sequences for tcdm_sram_responder.
module tb_tcdm_sram_responder;
    localparam logic [31:0] BASE = 32'h1C00_0000;
    localparam logic [31:0] BAD  = 32'hBADA_CCE5;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic        req = 0, wen = 1, gnt, rv, opc;
    logic [31:0] add = BASE, wdata = 0, rd;
    logic [3:0]  be = 0;
    logic        req1 = 0, wen1 = 1, gnt1, rv1, opc1;
    logic [31:0] add1 = BASE, wdata1 = 0, rd1;
    logic [3:0]  be1 = 0;
    logic        req2 = 0, wen2 = 1, gnt2, rv2, opc2;
    logic [31:0] add2 = BASE, wdata2 = 0, rd2;
    logic [3:0]  be2 = 0;

    tcdm_sram_responder u0 (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .r_valid_o(rv), .r_rdata_o(rd), .r_opc_o(opc)
    );
    tcdm_sram_responder #(.LATENCY(4), .MAX_OUTSTANDING(2)) u1 (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req1), .add_i(add1), .wen_i(wen1),
        .wdata_i(wdata1), .be_i(be1), .gnt_o(gnt1), .r_valid_o(rv1), .r_rdata_o(rd1), .r_opc_o(opc1)
    );
    tcdm_sram_responder #(.STALL_EVERY(3)) u2 (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req2), .add_i(add2), .wen_i(wen2),
        .wdata_i(wdata2), .be_i(be2), .gnt_o(gnt2), .r_valid_o(rv2), .r_rdata_o(rd2), .r_opc_o(opc2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        wen;
        logic [31:0] add;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_opc;
    } vec_t;

    vec_t vt[14];

    task automatic op0(input vec_t v, input int i);
        int lat;
        @(negedge clk);
        req = 1; wen = v.wen; add = v.add; wdata = v.wdata; be = v.be;
        #1 chk($sformatf("gnt[%0d]", i), 32'(gnt), 1);
        @(posedge clk);
        #1 req = 0; wdata = 32'hFFFF_FFFF; be = 4'hF; wen = 0;
        for (lat = 1; lat <= 10; lat++) begin
            @(negedge clk);
            if (rv) break;
            if (lat == 1) chk($sformatf("idle_rdata[%0d]", i), rd, 0);
        end
        wen = 1;
        chk($sformatf("latency[%0d]", i), 32'(lat), 2);
        chk($sformatf("rdata[%0d]", i), rd, v.exp_rd);
        chk($sformatf("opc[%0d]", i), 32'(opc), 32'(v.exp_opc));
    endtask

    initial begin
        logic [7:0] pat;
        int nhs, nrsp, outst;
        vt[0]  = '{0, BASE + 32'h10,  32'hDEAD_BEEF, 4'hF, 32'h0,          0};
        vt[1]  = '{1, BASE + 32'h10,  32'h0,         4'h0, 32'hDEAD_BEEF,  0};
        vt[2]  = '{0, BASE + 32'h20,  32'h0,         4'hF, 32'h0,          0};
        vt[3]  = '{0, BASE + 32'h20,  32'hAABB_CCDD, 4'h5, 32'h0,          0};
        vt[4]  = '{1, BASE + 32'h20,  32'h0,         4'h0, 32'h00BB_00DD,  0};
        vt[5]  = '{1, BASE + 32'h1000, 32'h0,        4'h0, BAD,            1};
        vt[6]  = '{1, BASE + 32'h2,   32'h0,         4'h0, BAD,            1};
        vt[7]  = '{0, BASE,           32'h1111_1111, 4'hF, 32'h0,          0};
        vt[8]  = '{0, BASE + 32'h2,   32'h1234_5678, 4'hF, BAD,            1};
        vt[9]  = '{1, BASE,           32'h0,         4'h0, 32'h1111_1111,  0};
        vt[10] = '{0, BASE + 32'h10,  32'h0,         4'h0, 32'h0,          0};
        vt[11] = '{1, BASE + 32'h10,  32'h0,         4'h0, 32'hDEAD_BEEF,  0};
        vt[12] = '{0, BASE + 32'hFFC, 32'hCAFE_F00D, 4'hF, 32'h0,          0};
        vt[13] = '{1, BASE + 32'hFFC, 32'h0,         4'h0, 32'hCAFE_F00D,  0};

        req = 1;
        #3;
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_valid", 32'(rv), 0);
        chk("reset_rdata", rd, 0);
        chk("reset_opc", 32'(opc), 0);
        @(negedge clk);
        req = 0;
        @(negedge clk);
        rst_ni = 1;

        for (int i = 0; i < 14; i++) op0(vt[i], i);

        // Write immediately followed by a read of the same word.
        @(negedge clk);
        req = 1; wen = 0; add = BASE + 32'h30; wdata = 32'h5A5A_5A5A; be = 4'hF;
        @(posedge clk);
        #1 wen = 1; wdata = 0;
        #1 chk("raw_gnt", 32'(gnt), 1);
        @(posedge clk);
        #1 req = 0;
        @(negedge clk);
        chk("raw_wr_valid", 32'(rv), 1);
        chk("raw_wr_rdata", rd, 0);
        @(negedge clk);
        chk("raw_rd_valid", 32'(rv), 1);
        chk("raw_rd_rdata", rd, 32'h5A5A_5A5A);
        @(negedge clk);
        chk("raw_after_valid", 32'(rv), 0);

        // Reset with two reads in flight.
        @(negedge clk);
        req = 1; wen = 1; add = BASE + 32'h10;
        @(posedge clk);
        @(posedge clk);
        #2 chk("pre_rst_valid", 32'(rv), 1);
        chk("pre_rst_rdata", rd, 32'hDEAD_BEEF);
        rst_ni = 0;
        #1 chk("rst_valid", 32'(rv), 0);
        chk("rst_rdata", rd, 0);
        chk("rst_gnt", 32'(gnt), 0);
        @(negedge clk);
        req = 0; rst_ni = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_valid[%0d]", c), 32'(rv), 0);
        end

        // LATENCY=4, MAX_OUTSTANDING=2: preload distinct words, then stream reads.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req1 = 1; wen1 = 0; add1 = BASE + 32'(4 * i); wdata1 = 32'h1000_0000 + 32'(i); be1 = 4'hF;
            @(posedge clk);
            #1 req1 = 0; wen1 = 1;
            repeat (5) @(posedge clk);
        end
        pat = 8'b0011_0011;
        nhs = 0; nrsp = 0; outst = 0;
        for (int c = 0; c < 60 && nrsp < 8; c++) begin
            @(negedge clk);
            req1 = nhs < 8; add1 = BASE + 32'(4 * nhs);
            #1;
            if (c < 8) chk($sformatf("lim_gnt[%0d]", c), 32'(gnt1), 32'(pat[c]));
            if (rv1) begin
                chk($sformatf("lim_rdata[%0d]", nrsp), rd1, 32'h1000_0000 + 32'(nrsp));
                nrsp++;
            end
            outst += int'(req1 && gnt1) - int'(rv1);
            chk($sformatf("lim_outst[%0d]", c), 32'(outst <= 2), 1);
            if (req1 && gnt1) nhs++;
        end
        req1 = 0;
        chk("lim_responses", 32'(nrsp), 8);

        // STALL_EVERY=3: counter starts from reset release.
        @(negedge clk);
        rst_ni = 0; req2 = 1; wen2 = 1; add2 = BASE;
        #1 chk("stall_rst_gnt", 32'(gnt2), 0);
        @(negedge clk);
        rst_ni = 1;
        for (int c = 0; c < 9; c++) begin
            #1 chk($sformatf("stall_gnt[%0d]", c), 32'(gnt2), 32'(c % 3 != 2));
            @(negedge clk);
        end
        req2 = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
